// File: rtl/lsu_store_buffer_pkg.sv
// Shared types and widths for the LSU store buffer.
package lsu_store_buffer_pkg;

  localparam int unsigned SB_XLEN    = 32;
  localparam int unsigned SB_NBYTES  = SB_XLEN / 8;
  localparam int unsigned SB_WADDR_W = SB_XLEN - 2;

  // Store access size as presented by the LSU.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } st_size_e;

  // One word-aligned, byte-enabled buffer entry.
  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [SB_XLEN-1:0]    data;
    logic [SB_NBYTES-1:0]  be;
  } stbuf_entry_t;

endpackage

// File: rtl/lsu_store_align.sv
// Converts a sized, byte-addressed store into a two-word byte-enable/data window.
module lsu_store_align
  import lsu_store_buffer_pkg::*;
#(
  parameter int unsigned XLEN = SB_XLEN
) (
  input  logic [1:0]            off,
  input  st_size_e              size,
  input  logic [XLEN-1:0]       data,
  output logic [2*(XLEN/8)-1:0] be_wide,
  output logic [2*XLEN-1:0]     data_wide,
  output logic                  crossing,
  output logic                  rsvd
);

  localparam int unsigned NB = XLEN / 8;

  logic [NB-1:0] mask;

  // Size mask shifted into position; upper half set means the store spills into the next word.
  always_comb begin
    mask = '0;
    rsvd = 1'b0;
    case (size)
      BYTE:    mask = NB'(1);
      HALF:    mask = NB'(3);
      WORD:    mask = '1;
      default: rsvd = 1'b1;
    endcase
    be_wide   = (2*NB)'(mask) << off;
    data_wide = (2*XLEN)'(data) << {off, 3'b000};
    crossing  = |be_wide[2*NB-1:NB];
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// In-order store buffer between the LSU store path and the DCCM write port,
// with byte-granular store-to-load forwarding.
module lsu_store_buffer
  import lsu_store_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = SB_XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [1:0]             st_size,
  input  logic [XLEN-1:0]        st_data,
  input  logic [XLEN-1:0]        ld_addr,
  output logic [3:0]             fwd_be,
  output logic [XLEN-1:0]        fwd_data,
  output logic [XLEN-1:0]        dccm_waddr,
  output logic                   dccm_wen,
  output logic [XLEN-1:0]        dccm_wdata,
  output logic [3:0]             dccm_wbe,
  input  logic                   dccm_wready,
  output logic                   sb_empty,
  output logic                   sb_full,
  output logic [$clog2(DEPTH):0] sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NB = XLEN / 8;

  // Entry storage and queue control.
  stbuf_entry_t   ent_q [DEPTH];
  stbuf_entry_t   ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [PW-1:0]  wr_idx, wr_idx1, rd_idx, fwd_idx;
  logic [CW-1:0]  free_slots, push_n, pop_n;
  logic           push, pop;

  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] data_wide;
  logic              crossing, rsvd;
  stbuf_entry_t      inc_a, inc_b;

  logic unused_ld_off;
  assign unused_ld_off = ^ld_addr[1:0];

  lsu_store_align #(.XLEN(XLEN)) u_align (
    .off       (st_addr[1:0]),
    .size      (st_size_e'(st_size)),
    .data      (st_data),
    .be_wide   (be_wide),
    .data_wide (data_wide),
    .crossing  (crossing),
    .rsvd      (rsvd)
  );

  // Incoming store split into its low-word and (optional) next-word entries.
  always_comb begin
    inc_a.waddr = st_addr[XLEN-1:2];
    inc_a.data  = data_wide[XLEN-1:0];
    inc_a.be    = be_wide[NB-1:0];
    inc_b.waddr = st_addr[XLEN-1:2] + (XLEN-2)'(1);
    inc_b.data  = data_wide[2*XLEN-1:XLEN];
    inc_b.be    = be_wide[2*NB-1:NB];
  end

  // Acceptance and drain handshakes; free space is taken from registered count only.
  always_comb begin
    wr_idx     = wr_ptr_q[PW-1:0];
    wr_idx1    = wr_idx + PW'(1);
    rd_idx     = rd_ptr_q[PW-1:0];
    free_slots = CW'(DEPTH) - count_q;
    st_ready   = rsvd | (free_slots >= CW'(2)) | ((free_slots >= CW'(1)) & ~crossing);
    push       = st_valid & st_ready & ~rsvd;
    dccm_wen   = (count_q != '0) & ~rst;
    pop        = dccm_wen & dccm_wready;
    push_n     = push ? (crossing ? CW'(2) : CW'(1)) : '0;
    pop_n      = pop ? CW'(1) : '0;
  end

  // Head entry drives the DCCM write port directly.
  always_comb begin
    dccm_waddr = {ent_q[rd_idx].waddr, 2'b00};
    dccm_wdata = ent_q[rd_idx].data;
    dccm_wbe   = ent_q[rd_idx].be;
    sb_empty   = (count_q == '0);
    sb_full    = (count_q == CW'(DEPTH));
    sb_count   = count_q;
  end

  // Next-state for pointers, valids, count and entry payloads.
  always_comb begin
    ent_d    = ent_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + push_n - pop_n;
    if (pop) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + CW'(1);
    end
    if (push) begin
      ent_d[wr_idx]   = inc_a;
      valid_d[wr_idx] = 1'b1;
      if (crossing) begin
        ent_d[wr_idx1]   = inc_b;
        valid_d[wr_idx1] = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + push_n;
    end
  end

  // Forwarding: scan oldest to youngest so later writers overwrite, then the incoming store.
  always_comb begin
    fwd_be   = '0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      fwd_idx = rd_idx + PW'(k);
      if (valid_q[fwd_idx] && (ent_q[fwd_idx].waddr == ld_addr[XLEN-1:2])) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (ent_q[fwd_idx].be[b]) begin
            fwd_be[b]          = 1'b1;
            fwd_data[8*b +: 8] = ent_q[fwd_idx].data[8*b +: 8];
          end
        end
      end
    end
    if (push) begin
      for (int b = 0; b < int'(NB); b++) begin
        if ((inc_b.waddr == ld_addr[XLEN-1:2]) && inc_b.be[b]) begin
          fwd_be[b]          = 1'b1;
          fwd_data[8*b +: 8] = inc_b.data[8*b +: 8];
        end
        if ((inc_a.waddr == ld_addr[XLEN-1:2]) && inc_a.be[b]) begin
          fwd_be[b]          = 1'b1;
          fwd_data[8*b +: 8] = inc_a.data[8*b +: 8];
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; qualified by valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule
